sdp_be_arbiter: RTL and testbench
=================================

Name: sdp_be_arbiter

Overview:
- Sequencer/arbiter in front of one simple-dual-port byte-enable BRAM: one write port (wa/wd/we/be), one read port (ra/rd), registered read data, 1-cycle read latency.
- Shares the single BRAM write port between two write requesters with round-robin arbitration.
- Schedules one read requester and resolves same-address read/write collisions, where BRAM read data is undefined, by stalling the read.
- Includes an anti-starvation escalation so a read cannot be stalled indefinitely.

Parameters:
- NBYTES, 4, number of byte lanes.
- BYTEWIDTH, 8, bits per lane; WDBITS = NBYTES*BYTEWIDTH.
- ABITS, 10, address width, shared by read and write.
- STALL_MAX, 3, consecutive collision stalls before read-priority mode; range 1..15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- w0_valid/w1_valid  in  1  write request.
- w0_ready/w1_ready  out  1  write accepted this cycle.
- w0_addr/w1_addr  in  ABITS  write address.
- w0_data/w1_data  in  WDBITS  write data.
- w0_be/w1_be  in  NBYTES  byte enables; lane i covers data[i*BYTEWIDTH +: BYTEWIDTH].
- r_valid  in  1  read request.
- r_ready  out  1  read accepted.
- r_addr  in  ABITS  read address.
- rsp_valid  out  1  read data valid; no backpressure.
- rsp_data  out  WDBITS  read data.
- ram_we  out  1  BRAM write enable.
- ram_wa  out  ABITS  BRAM write address.
- ram_wd  out  WDBITS  BRAM write data.
- ram_be  out  NBYTES  BRAM byte enables.
- ram_ra  out  ABITS  BRAM read address.
- ram_rd  in  WDBITS  BRAM registered read data.

Behaviour:
- Ready, ram_* and grant logic are combinational from requests and registered state. State registers: rr_last (1b), stall_cnt (4b), mode, rsp_valid.
- Reset (async, rst_n=0):
  - rr_last=1, so w0 wins the first tie.
  - stall_cnt=0, mode=NORMAL, rsp_valid=0.
  - All ready outputs 0, ram_we=0.
  - Reset mid-operation drops any in-flight response; rsp_valid never asserts for a read accepted before reset.
- Write arbitration (NORMAL mode):
  - Only one valid: that requester is granted.
  - Both valid: grant the one != rr_last.
  - rr_last updates to the granted index only on a grant.
  - Granted requester drives ram_wa/ram_wd/ram_be; its ready=1.
  - ram_we = grant && (be != 0). A be==0 write is still handshaked (ready=1) but performs no RAM write.
- Read:
  - ram_ra = r_addr at all times.
  - collide = write granted && r_addr == granted addr && granted be != 0.
  - r_ready = r_valid && !collide. The granted write always proceeds.
  - rsp_valid is asserted the cycle after r_valid && r_ready, with rsp_data = ram_rd. Latency is exactly 1.
  - Back-to-back reads: one accepted per cycle.
- Anti-starvation, states NORMAL and READ_PRIO:
  - NORMAL: stall_cnt increments on each cycle with r_valid && collide, and clears on a read accept or on !r_valid.
  - NORMAL -> READ_PRIO when stall_cnt reaches STALL_MAX.
  - READ_PRIO: write requesters whose addr == r_addr and be != 0 are masked from arbitration. Non-conflicting requesters arbitrate normally; if both conflict, no write is granted. r_ready = r_valid.
  - READ_PRIO -> NORMAL after exactly one cycle; stall_cnt clears.
- Simultaneous w0/w1 writes to the same address: serialized by round-robin, never merged.
- A write and a read in the same cycle to different addresses are both accepted.

Optional Feature:
- Macro: SDP_BE_ARB_PERF_EN.
- Defined: adds outputs perf_w0_cnt, perf_w1_cnt and perf_stall_cnt, each 32 bits.
  - perf_w0_cnt / perf_w1_cnt count granted writes per requester.
  - perf_stall_cnt counts collision stall cycles.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sdp_be_arb_pkg: mode enum (NORMAL, READ_PRIO) and a write-request struct {addr, data, be}. Width constants derived from the parameters as localparams.
- One sub-module, sdp_rr_arb2: 2-way round-robin arbiter with a mask input, outputs grant[1:0], and internal rr_last.

Test Plan:
- Reset release, w0 writes addr 5, data 0xAABBCCDD, be 4'b1111; next cycle read addr 5 -> ram_we=1 in the write cycle; rsp_valid one cycle after r_ready, with rsp_data=0xAABBCCDD.
- w0 and w1 valid for 4 cycles to different addresses -> grants alternate w0,w1,w0,w1; exactly one ready per cycle; ram_we=1 every cycle.
- Partial write: preload 0x11223344 at addr 9, then write 0xFFFFFFFF with be=4'b0101, then read -> rsp_data=0x11FF33FF.
- Collision: w0 writes addr 7 continuously while reading addr 7 -> r_ready=0 for 3 cycles; READ_PRIO on the 4th, with r_ready=1 and w0_ready=0; NORMAL afterwards.
- be=0 write to addr 3 while reading addr 3 -> w0_ready=1, ram_we=0, r_ready=1 (no collision).
- Assert rst_n=0 the cycle after a read accept -> rsp_valid stays 0; readies 0 while in reset.

Source files
------------

// File: rtl/sdp_be_arb_pkg.sv
// Shared types and default widths for the simple-dual-port byte-enable BRAM arbiter.
// The top module derives its parameter defaults from the localparams below.
package sdp_be_arb_pkg;

    localparam int NBYTES_DEF    = 4;
    localparam int BYTEWIDTH_DEF = 8;
    localparam int WDBITS_DEF    = NBYTES_DEF * BYTEWIDTH_DEF;
    localparam int ABITS_DEF     = 10;
    localparam int STALL_MAX_DEF = 3;
    localparam int STALL_BITS    = 4;

    typedef enum logic {
        NORMAL    = 1'b0,
        READ_PRIO = 1'b1
    } mode_e;

    typedef struct packed {
        logic [ABITS_DEF-1:0]  addr;
        logic [WDBITS_DEF-1:0] data;
        logic [NBYTES_DEF-1:0] be;
    } wr_req_t;

    // A write only disturbs a read when it actually touches at least one lane.
    function automatic logic req_conflicts(input wr_req_t req, input logic [ABITS_DEF-1:0] raddr);
        return (req.be != '0) && (req.addr == raddr);
    endfunction

endpackage

// File: rtl/sdp_rr_arb2.sv
// Two-way round-robin arbiter with per-requester mask; remembers the last winner
// so the other requester wins the next tie.
module sdp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_grant
);

    logic       r_rr_last;
    logic [1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    always_comb begin
        o_grant = w_elig;
        if (&w_elig) begin
            o_grant = r_rr_last ? 2'b01 : 2'b10;
        end
    end

    // Reset value 1 lets requester 0 win the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (|o_grant) begin
            r_rr_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/sdp_be_arbiter.sv
// Write-port round-robin sharing plus read scheduling with collision stall and
// anti-starvation escalation for one byte-enable BRAM. Optional perf counters: SDP_BE_ARB_PERF_EN.
module sdp_be_arbiter
    import sdp_be_arb_pkg::*;
#(
    parameter int NBYTES    = NBYTES_DEF,
    parameter int BYTEWIDTH = BYTEWIDTH_DEF,
    parameter int ABITS     = ABITS_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF,
    localparam int WDBITS   = NBYTES * BYTEWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ABITS-1:0]  w0_addr,
    input  logic [WDBITS-1:0] w0_data,
    input  logic [NBYTES-1:0] w0_be,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ABITS-1:0]  w1_addr,
    input  logic [WDBITS-1:0] w1_data,
    input  logic [NBYTES-1:0] w1_be,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ABITS-1:0]  r_addr,
    output logic              rsp_valid,
    output logic [WDBITS-1:0] rsp_data,
    output logic              ram_we,
    output logic [ABITS-1:0]  ram_wa,
    output logic [WDBITS-1:0] ram_wd,
    output logic [NBYTES-1:0] ram_be,
    output logic [ABITS-1:0]  ram_ra,
    input  logic [WDBITS-1:0] ram_rd
`ifdef SDP_BE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_w0_cnt,
    output logic [31:0]       perf_w1_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    mode_e                 r_mode, w_mode_nxt;
    logic [STALL_BITS-1:0] r_stall_cnt, w_stall_nxt;
    logic                  r_rsp_valid;

    wr_req_t    w_req0, w_req1, w_sel;
    logic       w_conf0, w_conf1;
    logic [1:0] w_mask, w_grant;
    logic       w_any_grant, w_collide, w_rd_accept;

    assign w_req0  = '{addr: w0_addr, data: w0_data, be: w0_be};
    assign w_req1  = '{addr: w1_addr, data: w1_data, be: w1_be};
    assign w_conf0 = req_conflicts(w_req0, r_addr);
    assign w_conf1 = req_conflicts(w_req1, r_addr);

    // In read-priority mode, writes that would corrupt the pending read sit out one cycle.
    assign w_mask = (r_mode == READ_PRIO) ? {w_conf1, w_conf0} : 2'b00;

    sdp_rr_arb2 u_rr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   ({w1_valid, w0_valid}),
        .i_mask  (w_mask),
        .o_grant (w_grant)
    );

    assign w_sel       = w_grant[1] ? w_req1 : w_req0;
    assign w_any_grant = |w_grant;
    assign w_collide   = w_any_grant && req_conflicts(w_sel, r_addr);
    assign w_rd_accept = r_valid && ((r_mode == READ_PRIO) || !w_collide);

    assign w0_ready  = w_grant[0] & rst_n;
    assign w1_ready  = w_grant[1] & rst_n;
    assign r_ready   = w_rd_accept & rst_n;
    assign ram_we    = w_any_grant & (w_sel.be != '0) & rst_n;
    assign ram_wa    = w_sel.addr;
    assign ram_wd    = w_sel.data;
    assign ram_be    = w_sel.be;
    assign ram_ra    = r_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = ram_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= NORMAL;
            r_stall_cnt <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_rsp_valid <= w_rd_accept;
        end
    end

    // Read-priority lasts exactly one cycle, then the stall count starts over.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_stall_nxt = r_stall_cnt;
        case (r_mode)
            NORMAL: begin
                if (r_valid && w_collide) begin
                    w_stall_nxt = r_stall_cnt + 1'b1;
                    if (w_stall_nxt == STALL_BITS'(STALL_MAX)) begin
                        w_mode_nxt = READ_PRIO;
                    end
                end else begin
                    w_stall_nxt = '0;
                end
            end
            READ_PRIO: begin
                w_mode_nxt  = NORMAL;
                w_stall_nxt = '0;
            end
            default: begin
                w_mode_nxt  = NORMAL;
                w_stall_nxt = '0;
            end
        endcase
    end

`ifdef SDP_BE_ARB_PERF_EN
    logic [31:0] r_perf_w0, r_perf_w1, r_perf_stall;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_w0    <= '0;
            r_perf_w1    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_grant[0] && (r_perf_w0 != '1)) r_perf_w0 <= r_perf_w0 + 32'd1;
            if (w_grant[1] && (r_perf_w1 != '1)) r_perf_w1 <= r_perf_w1 + 32'd1;
            if (r_valid && !w_rd_accept && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_w0_cnt    = r_perf_w0;
    assign perf_w1_cnt    = r_perf_w1;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_sdp_be_arbiter.sv
// Self-checking bench for sdp_be_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a cycle-level behavioural model with a BRAM model.
module tb_sdp_be_arbiter;

   localparam int NB   = 4;
   localparam int AB   = 10;
   localparam int WD   = 32;
   localparam int SMAX = 3;

   logic          clk;
   logic          rst_n;
   logic          w0_valid, w0_ready, w1_valid, w1_ready;
   logic [AB-1:0] w0_addr, w1_addr, r_addr, ram_wa, ram_ra;
   logic [WD-1:0] w0_data, w1_data, rsp_data, ram_wd, ram_rd;
   logic [NB-1:0] w0_be, w1_be, ram_be;
   logic          r_valid, r_ready, rsp_valid, ram_we;
`ifdef SDP_BE_ARB_PERF_EN
   logic [31:0]   perf_w0_cnt, perf_w1_cnt, perf_stall_cnt;
`endif

   typedef struct {
      logic          w0v;
      logic [AB-1:0] w0a;
      logic [WD-1:0] w0d;
      logic [NB-1:0] w0be;
      logic          w1v;
      logic [AB-1:0] w1a;
      logic [WD-1:0] w1d;
      logic [NB-1:0] w1be;
      logic          rv;
      logic [AB-1:0] ra;
      logic          expW0r;
      logic          expW1r;
      logic          expRr;
      logic          expWe;
   } vec_t;

   int nVectors = 0;
   int nMiscompares = 0;

   logic [WD-1:0] bram   [0:1023] = '{default: '0};
   logic [WD-1:0] shadow [0:1023] = '{default: '0};

   int            mRrLast;
   int            mStall;
   bit            mPrio;
   bit            mPend;
   logic [WD-1:0] mPendData;

   sdp_be_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .w0_valid  (w0_valid),
      .w0_ready  (w0_ready),
      .w0_addr   (w0_addr),
      .w0_data   (w0_data),
      .w0_be     (w0_be),
      .w1_valid  (w1_valid),
      .w1_ready  (w1_ready),
      .w1_addr   (w1_addr),
      .w1_data   (w1_data),
      .w1_be     (w1_be),
      .r_valid   (r_valid),
      .r_ready   (r_ready),
      .r_addr    (r_addr),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ram_we    (ram_we),
      .ram_wa    (ram_wa),
      .ram_wd    (ram_wd),
      .ram_be    (ram_be),
      .ram_ra    (ram_ra),
      .ram_rd    (ram_rd)
`ifdef SDP_BE_ARB_PERF_EN
      ,
      .perf_w0_cnt    (perf_w0_cnt),
      .perf_w1_cnt    (perf_w1_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM with byte enables and a registered, read-old-data read port
   always @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < NB; i++) begin
            if (ram_be[i]) bram[ram_wa][i*8 +: 8] <= ram_wd[i*8 +: 8];
         end
      end
      ram_rd <= bram[ram_ra];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w0v, input logic [AB-1:0] w0a, input logic [WD-1:0] w0d,
                               input logic [NB-1:0] w0be, input logic w1v, input logic [AB-1:0] w1a,
                               input logic [WD-1:0] w1d, input logic [NB-1:0] w1be,
                               input logic rv, input logic [AB-1:0] ra);
      vec_t v;
      v = '{w0v, w0a, w0d, w0be, w1v, w1a, w1d, w1be, rv, ra, 1'b0, 1'b0, 1'b0, 1'b0};
      return v;
   endfunction

   task automatic modelReset();
      mRrLast = 1;
      mStall  = 0;
      mPrio   = 1'b0;
      mPend   = 1'b0;
   endtask

   // Reference behaviour for one clock cycle, evaluated from the currently driven inputs
   task automatic modelStep();
      bit            m0, m1, eWe, col, eRr;
      int            g;
      logic [AB-1:0] ga;
      logic [WD-1:0] gd;
      logic [NB-1:0] gbe;
      check("rsp_valid", 64'(rsp_valid), 64'(mPend));
      if (mPend) check("rsp_data", 64'(rsp_data), 64'(mPendData));
      m0 = w0_valid && !(mPrio && w0_be != 0 && w0_addr == r_addr);
      m1 = w1_valid && !(mPrio && w1_be != 0 && w1_addr == r_addr);
      if (m0 && m1) g = (mRrLast == 0) ? 1 : 0;
      else if (m0)  g = 0;
      else if (m1)  g = 1;
      else          g = -1;
      ga  = (g == 1) ? w1_addr : w0_addr;
      gd  = (g == 1) ? w1_data : w0_data;
      gbe = (g == 1) ? w1_be : w0_be;
      eWe = (g >= 0) && (gbe != 0);
      col = eWe && (ga == r_addr);
      eRr = r_valid && (mPrio || !col);
      check("w0_ready", 64'(w0_ready), 64'(g == 0));
      check("w1_ready", 64'(w1_ready), 64'(g == 1));
      check("ram_we", 64'(ram_we), 64'(eWe));
      check("r_ready", 64'(r_ready), 64'(eRr));
      check("ram_ra", 64'(ram_ra), 64'(r_addr));
      if (eWe) begin
         check("ram_wa", 64'(ram_wa), 64'(ga));
         check("ram_wd", 64'(ram_wd), 64'(gd));
         check("ram_be", 64'(ram_be), 64'(gbe));
      end
      mPend = eRr;
      if (eRr) mPendData = shadow[r_addr];
      if (eWe) begin
         for (int i = 0; i < NB; i++) begin
            if (gbe[i]) shadow[ga][i*8 +: 8] = gd[i*8 +: 8];
         end
      end
      if (g >= 0) mRrLast = g;
      if (mPrio) begin
         mPrio  = 1'b0;
         mStall = 0;
      end else if (r_valid && col) begin
         mStall++;
         if (mStall >= SMAX) mPrio = 1'b1;
      end else begin
         mStall = 0;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      w0_valid = v.w0v; w0_addr = v.w0a; w0_data = v.w0d; w0_be = v.w0be;
      w1_valid = v.w1v; w1_addr = v.w1a; w1_data = v.w1d; w1_be = v.w1be;
      r_valid  = v.rv;  r_addr  = v.ra;
      #2;
      modelStep();
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      check({tag, ".w0_ready"}, 64'(w0_ready), 64'(v.expW0r));
      check({tag, ".w1_ready"}, 64'(w1_ready), 64'(v.expW1r));
      check({tag, ".r_ready"}, 64'(r_ready), 64'(v.expRr));
      check({tag, ".ram_we"}, 64'(ram_we), 64'(v.expWe));
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      w0_valid = 1'b1; w0_be = 4'hF; w1_valid = 1'b1; w1_be = 4'hF; r_valid = 1'b1;
      w0_addr = 10'd1; w1_addr = 10'd2; r_addr = 10'd3;
      modelReset();
      #2;
      check("reset.w0_ready", 64'(w0_ready), 64'd0);
      check("reset.w1_ready", 64'(w1_ready), 64'd0);
      check("reset.r_ready", 64'(r_ready), 64'd0);
      check("reset.ram_we", 64'(ram_we), 64'd0);
      @(posedge clk);
      #1;
      check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
      w0_valid = 1'b0; w1_valid = 1'b0; r_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl [8];
      vec_t v;
      tbl[0] = '{1, 10'h10, 32'h1000_0000, 4'hF, 1, 10'h20, 32'h2000_0000, 4'hF, 0, 10'h00, 1, 0, 0, 1};
      tbl[1] = '{1, 10'h11, 32'h1000_0001, 4'hF, 1, 10'h21, 32'h2000_0001, 4'hF, 0, 10'h00, 0, 1, 0, 1};
      tbl[2] = '{1, 10'h12, 32'h1000_0002, 4'hF, 1, 10'h22, 32'h2000_0002, 4'hF, 0, 10'h00, 1, 0, 0, 1};
      tbl[3] = '{1, 10'h13, 32'h1000_0003, 4'hF, 1, 10'h23, 32'h2000_0003, 4'hF, 0, 10'h00, 0, 1, 0, 1};
      tbl[4] = '{1, 10'h03, 32'hDEAD_BEEF, 4'h0, 0, 10'h00, 32'h0,         4'h0, 1, 10'h03, 1, 0, 1, 0};
      tbl[5] = '{1, 10'h30, 32'h3030_3030, 4'hF, 0, 10'h00, 32'h0,         4'h0, 1, 10'h31, 1, 0, 1, 1};
      tbl[6] = '{0, 10'h00, 32'h0,         4'h0, 0, 10'h00, 32'h0,         4'h0, 0, 10'h00, 0, 0, 0, 0};
      tbl[7] = '{0, 10'h00, 32'h0,         4'h0, 1, 10'h40, 32'h4040_4040, 4'h3, 0, 10'h00, 0, 1, 0, 1};

      rst_n = 1'b0;
      w0_valid = 0; w1_valid = 0; r_valid = 0;
      w0_addr = 0; w1_addr = 0; r_addr = 0; w0_data = 0; w1_data = 0; w0_be = 0; w1_be = 0;
      doReset();

      // Write then read back the same word
      applyStimulus(mk(1, 10'd5, 32'hAABB_CCDD, 4'hF, 0, 0, 0, 0, 0, 0));
      check("basic.ram_we", 64'(ram_we), 64'd1);
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'd5));
      check("basic.r_ready", 64'(r_ready), 64'd1);
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("basic.rsp_valid", 64'(rsp_valid), 64'd1);
      check("basic.rsp_data", 64'(rsp_data), 64'hAABB_CCDD);

      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("tbl%0d", i), tbl[i]);
      end

      // Partial-lane overwrite keeps the unselected bytes
      applyStimulus(mk(1, 10'd9, 32'h1122_3344, 4'hF, 0, 0, 0, 0, 0, 0));
      applyStimulus(mk(1, 10'd9, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0, 0, 0, 0));
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'd9));
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check("partial.rsp_data", 64'(rsp_data), 64'h11FF_33FF);

      // Persistent collision escalates to read priority on the fourth cycle
      doReset();
      v = mk(1, 10'd7, 32'hCAFE_0007, 4'hF, 0, 0, 0, 0, 1, 10'd7);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(v);
         check($sformatf("stall%0d.r_ready", i), 64'(r_ready), 64'd0);
         check($sformatf("stall%0d.w0_ready", i), 64'(w0_ready), 64'd1);
      end
      applyStimulus(v);
      check("prio.r_ready", 64'(r_ready), 64'd1);
      check("prio.w0_ready", 64'(w0_ready), 64'd0);
      check("prio.ram_we", 64'(ram_we), 64'd0);
      applyStimulus(v);
      check("after.r_ready", 64'(r_ready), 64'd0);
      check("after.w0_ready", 64'(w0_ready), 64'd1);
      check("after.rsp_valid", 64'(rsp_valid), 64'd1);
      check("after.rsp_data", 64'(rsp_data), 64'hCAFE_0007);

      // Reset right after a read accept drops its response
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 10'd5));
      check("rstmid.r_ready", 64'(r_ready), 64'd1);
      #1;
      rst_n = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      check("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
      doReset();
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Random traffic, then a tight address range to provoke escalations
      for (int i = 0; i < 600; i++) begin
         int amax;
         amax = (i < 300) ? 3 : 1;
         v = mk($urandom_range(0, 3) != 0, AB'($urandom_range(0, amax)), $urandom,
                ($urandom_range(0, 5) == 0) ? 4'h0 : NB'($urandom_range(1, 15)),
                $urandom_range(0, 3) != 0, AB'($urandom_range(0, amax)), $urandom,
                ($urandom_range(0, 5) == 0) ? 4'h0 : NB'($urandom_range(1, 15)),
                $urandom_range(0, 4) != 0, AB'($urandom_range(0, amax)));
         applyStimulus(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
